lmdpl_phase_ctrl: RTL



---
 rtl/lmdpl_phase_ctrl_pkg.sv | 29 ++
 rtl/lmdpl_phase_ctrl_if.sv | 30 +++
 rtl/lmdpl_phase_cnt.sv | 26 ++
 rtl/lmdpl_phase_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/lmdpl_phase_ctrl_pkg.sv
// Shared types and sizing helpers for the LMDPL phase sequencer.
// Build option: LMDPL_MASK_REFRESH_EN (see lmdpl_phase_ctrl.sv).
package lmdpl_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MASK,
    PRE,
    EVAL,
    CAPT,
    DONE
  } state_t;

  localparam int DEF_NUM_ROUNDS  = 10;
  localparam int DEF_PRE_CYCLES  = 1;
  localparam int DEF_EVAL_CYCLES = 4;

  // Wide enough to hold the longer of the two phase lengths.
  function automatic int phase_cnt_width(input int pre_cycles, input int eval_cycles);
    int longest;
    longest = (pre_cycles > eval_cycles) ? pre_cycles : eval_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

  function automatic int round_width(input int num_rounds);
    return (num_rounds > 1) ? $clog2(num_rounds) : 1;
  endfunction

endpackage

// File: rtl/lmdpl_phase_ctrl_if.sv
// Control bundle between the AES top-level/RNG side and the LMDPL phase sequencer.
// master = sequencer, slave = the surrounding control and RNG logic.
interface lmdpl_phase_ctrl_if
  import lmdpl_ctrl_pkg::*;
#(
  parameter int RW = round_width(DEF_NUM_ROUNDS)
);

  logic          start;
  logic          mask_ack;
  logic          mask_req;
  logic          precharge;
  logic          eval_en;
  logic          capture;
  logic [RW-1:0] round_idx;
  logic          last_round;
  logic          busy;
  logic          done;

  modport master (
    input  start, mask_ack,
    output mask_req, precharge, eval_en, capture, round_idx, last_round, busy, done
  );

  modport slave (
    output start, mask_ack,
    input  mask_req, precharge, eval_en, capture, round_idx, last_round, busy, done
  );

endinterface

// File: rtl/lmdpl_phase_cnt.sv
// Loadable down-counter that saturates at zero; times the PRE and EVAL phases.
module lmdpl_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (!zero) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/lmdpl_phase_ctrl.sv
// Precharge/evaluate/capture sequencer for the LMDPL round datapath with RNG mask fetch.
// Define LMDPL_MASK_REFRESH_EN to fetch a fresh mask before every round, not only the first.
module lmdpl_phase_ctrl
  import lmdpl_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS  = DEF_NUM_ROUNDS,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int EVAL_CYCLES = DEF_EVAL_CYCLES,
  parameter int RW          = round_width(NUM_ROUNDS)
) (
  input logic                clk,
  input logic                rst,
  lmdpl_phase_ctrl_if.master bus
);

  localparam int            CW        = phase_cnt_width(PRE_CYCLES, EVAL_CYCLES);
  localparam logic [RW-1:0] LAST_IDX  = RW'(NUM_ROUNDS - 1);
  // Counter holds the remaining cycles after the current one, so exit happens at zero.
  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [RW-1:0] round_reg, round_next;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_zero;
  logic          last_round;

  lmdpl_phase_cnt #(
    .W(CW)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign last_round = (round_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      round_reg <= '0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    round_next    = round_reg;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    bus.precharge = 1'b0;
    bus.eval_en   = 1'b0;
    bus.mask_req  = 1'b0;
    bus.capture   = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.precharge = 1'b1;
        if (bus.start) begin
          state_next = MASK;
        end
      end
      MASK: begin
        bus.precharge = 1'b1;
        bus.mask_req  = 1'b1;
        bus.busy      = 1'b1;
        if (bus.mask_ack) begin
          state_next   = PRE;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
        end
      end
      PRE: begin
        bus.precharge = 1'b1;
        bus.busy      = 1'b1;
        if (cnt_zero) begin
          state_next   = EVAL;
          cnt_load     = 1'b1;
          cnt_load_val = EVAL_LOAD;
        end
      end
      EVAL: begin
        bus.eval_en = 1'b1;
        bus.busy    = 1'b1;
        if (cnt_zero) begin
          state_next = CAPT;
        end
      end
      CAPT: begin
        // Evaluation stays enabled so the round register captures settled rails.
        bus.eval_en = 1'b1;
        bus.capture = 1'b1;
        bus.busy    = 1'b1;
        if (last_round) begin
          state_next = DONE;
        end else begin
          round_next = round_reg + RW'(1);
`ifdef LMDPL_MASK_REFRESH_EN
          state_next = MASK;
`else
          state_next   = PRE;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
`endif
        end
      end
      DONE: begin
        bus.precharge = 1'b1;
        bus.done      = 1'b1;
        bus.busy      = 1'b1;
        state_next    = IDLE;
        round_next    = '0;
      end
      default: begin
        bus.precharge = 1'b1;
        state_next    = IDLE;
        round_next    = '0;
      end
    endcase
  end

  assign bus.round_idx  = round_reg;
  assign bus.last_round = last_round;

endmodule
